// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg
//   Shared types and constants for the instruction-memory program loader.
//   state_t   : loader FSM states
//   LEN_BYTES : number of bytes carrying the program length at stream start
package inst_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        INST_HI = 3'd3,
        INST_LO = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int LEN_BYTES = 2;
    localparam int LEN_W     = 8 * LEN_BYTES;

endpackage

// File: rtl/inst_loader_if.sv
// inst_loader_if
//   Bundles the byte-stream handshake and the instruction-memory write port.
//   byte_in/byte_valid/byte_ready : incoming program bytes (valid/ready)
//   wr_en/wr_addr/wr_data         : one-cycle write strobe to instruction memory
//   modport master : loader side (consumes bytes, drives writes)
//   modport slave  : stream source / memory side
interface inst_loader_if #(
    parameter int A = 16,
    parameter int W = 9
);
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/inst_loader.sv
// inst_loader
//   Fills instruction memory from a length-prefixed byte stream. Two length
//   bytes (high first) give N, then N byte pairs each form one W-bit
//   instruction written at consecutive addresses from 0.
//   Ports:
//     i_clk    : clock, all state on rising edge
//     i_reset  : synchronous active-high reset
//     i_start  : begin a load (honoured in IDLE or DONE only)
//     bus      : byte stream in, memory write port out (master modport)
//     o_busy   : load in progress (LEN_HI..INST_LO)
//     o_done   : load finished, held until Start or Reset
//     o_error  : length exceeded memory depth, held until Start or Reset
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | after reset, waiting for Start
//   LEN_HI  | waiting for length high byte
//   LEN_LO  | waiting for length low byte, then range check
//   INST_HI | waiting for instruction high byte
//   INST_LO | waiting for instruction low byte, issues the write
//   DONE    | load complete (or rejected), waiting for Start
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int A = 16,
    parameter int W = 9
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    inst_loader_if.master     bus,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [A:0]         r_cnt;
    logic [LEN_W-1:0]   r_len;
    logic [W-9:0]       r_hi;
    logic               r_wr_en;
    logic [A-1:0]       r_wr_addr;
    logic [W-1:0]       r_wr_data;
    logic               r_done;
    logic               r_error;

    logic               w_ready;
    logic               w_busy;
    logic               w_accept;
    logic [LEN_W-1:0]   w_len;
    logic [A:0]         w_cnt_inc;
    logic               w_last;
    logic               w_too_big;

    assign w_accept  = bus.byte_valid && w_ready;
    assign w_len     = {r_len[LEN_W-1:8], bus.byte_in};
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_last    = (32'(w_cnt_inc) == 32'(r_len));
    // Depth compare done at 32 bits so N == 2**A is legal even when A == 16.
    assign w_too_big = (32'(w_len) > (32'd1 << A));

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_state_nxt = LEN_HI;
            end
            LEN_HI: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (w_accept) w_state_nxt = LEN_LO;
            end
            LEN_LO: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (w_accept) begin
                    if (w_len == '0 || w_too_big) w_state_nxt = DONE;
                    else                          w_state_nxt = INST_HI;
                end
            end
            INST_HI: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (w_accept) w_state_nxt = INST_LO;
            end
            INST_LO: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (w_accept) w_state_nxt = w_last ? DONE : INST_HI;
            end
            DONE: begin
                if (i_start) w_state_nxt = LEN_HI;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_hi      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wr_en <= 1'b0;
            r_done  <= (w_state_nxt == DONE);
            case (r_state)
                LEN_HI: begin
                    if (w_accept) r_len[LEN_W-1:8] <= bus.byte_in;
                end
                LEN_LO: begin
                    if (w_accept) begin
                        r_len   <= w_len;
                        r_cnt   <= '0;
                        r_error <= w_too_big;
                    end
                end
                INST_HI: begin
                    // Upper 16-W bits of the high byte are discarded.
                    if (w_accept) r_hi <= bus.byte_in[W-9:0];
                end
                INST_LO: begin
                    if (w_accept) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_cnt[A-1:0];
                        r_wr_data <= {r_hi, bus.byte_in};
                        r_cnt     <= w_cnt_inc;
                    end
                end
                DONE: begin
                    if (i_start) r_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign o_busy         = w_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;

endmodule
